// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a two-stage sync/blanking pipeline.
// Stage 0 is the raw (x,y) raster; hsync, vsync and rgb trail it by two pixel steps.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 128,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 9,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 28
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       pix_en,
    input  logic [2:0] rgb_in,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] rgb
);

    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic x_wrap;
    logic y_wrap;
    logic hs0;
    logic vs0;
    logic hs1;
    logic vs1;
    logic act1;

    assign x_wrap      = (x == H_LAST);
    assign y_wrap      = (y == V_LAST);
    assign active      = (x < H_ACT) && (y < V_ACT);
    assign line_start  = (x == 10'd0);
    assign frame_start = (x == 10'd0) && (y == 10'd0);
    assign hs0         = !((x >= H_SS) && (x < H_SE));
    assign vs0         = !((y >= V_SS) && (y < V_SE));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            x         <= '0;
            y         <= '0;
            frame_cnt <= '0;
        end else if (pix_en) begin
            x <= x_wrap ? 10'd0 : x + 10'd1;
            if (x_wrap) begin
                y <= y_wrap ? 10'd0 : y + 10'd1;
                if (y_wrap)
                    frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    // rgb_in belongs to the pixel now held in stage 1, so blank against act1.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            hs1   <= 1'b1;
            vs1   <= 1'b1;
            act1  <= 1'b0;
            hsync <= 1'b1;
            vsync <= 1'b1;
            rgb   <= 3'b000;
        end else if (pix_en) begin
            hs1   <= hs0;
            vs1   <= vs0;
            act1  <= active;
            hsync <= hs1;
            vsync <= vs1;
            rgb   <= act1 ? rgb_in : 3'b000;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a reduced raster.
// A queue holds the expected delayed outputs of every issued pixel.
module tb_vga_timing_gen;

    localparam int HA = 6;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int VA = 4;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [2:0] rgb;
    } out_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pix_en = 1'b0;
    logic [2:0] rgb_in = 3'b000;
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_cnt;
    logic       hsync;
    logic       vsync;
    logic [2:0] rgb;

    int total = 0;
    int bad = 0;
    int mx = 0;
    int my = 0;
    int mfc = 0;
    int mode = 0;
    logic [2:0] prev_col = 3'b000;
    out_t q[$];
    out_t last;
    out_t rst_out;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .pix_en     (pix_en),
        .rgb_in     (rgb_in),
        .x          (x),
        .y          (y),
        .active     (active),
        .line_start (line_start),
        .frame_start(frame_start),
        .frame_cnt  (frame_cnt),
        .hsync      (hsync),
        .vsync      (vsync),
        .rgb        (rgb)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] col(input int xx);
        return (mode == 1) ? xx[2:0] : 3'd7;
    endfunction

    // One clock: drive, advance the model on pix_en, compare against scoreboard.
    task automatic step(input logic pe);
        out_t e;
        logic act;
        logic [9:0] ex;
        logic [9:0] ey;
        logic [7:0] ef;
        pix_en = pe;
        rgb_in = pe ? prev_col : 3'($urandom);
        if (pe) begin
            act   = (mx < HA) && (my < VA);
            e.hs  = !((mx >= HA + HF) && (mx < HA + HF + HS));
            e.vs  = !((my >= VA + VF) && (my < VA + VF + VS));
            e.rgb = act ? col(mx) : 3'b000;
            q.push_back(e);
            prev_col = col(mx);
        end
        @(posedge clk);
        #1;
        if (pe) begin
            if (mx == HT - 1) begin
                mx = 0;
                if (my == VT - 1) begin
                    my  = 0;
                    mfc = (mfc + 1) % 256;
                end else begin
                    my++;
                end
            end else begin
                mx++;
            end
            last = q.pop_front();
        end
        ex = mx[9:0];
        ey = my[9:0];
        ef = mfc[7:0];
        total++;
        if ({hsync, vsync, rgb} !== last) begin
            bad++;
            $display("FAIL pipe_out: got hs=%b vs=%b rgb=%0d want hs=%b vs=%b rgb=%0d",
                     hsync, vsync, rgb, last.hs, last.vs, last.rgb);
        end
        total++;
        if (x !== ex || y !== ey || frame_cnt !== ef) begin
            bad++;
            $display("FAIL counters: got x=%0d y=%0d fc=%0d want x=%0d y=%0d fc=%0d",
                     x, y, frame_cnt, ex, ey, ef);
        end
        total++;
        if (active !== ((mx < HA) && (my < VA)) || line_start !== (mx == 0)
            || frame_start !== (mx == 0 && my == 0)) begin
            bad++;
            $display("FAIL stage0_flags: got act=%b ls=%b fs=%b at x=%0d y=%0d",
                     active, line_start, frame_start, mx, my);
        end
    endtask

    task automatic do_reset(input logic pe);
        rst    = 1'b1;
        pix_en = pe;
        rgb_in = 3'($urandom);
        @(posedge clk);
        #1;
        total++;
        if (x !== 10'd0 || y !== 10'd0) begin
            bad++;
            $display("FAIL rst_xy: got x=%0d y=%0d want 0 0", x, y);
        end
        total++;
        if (frame_cnt !== 8'd0) begin
            bad++;
            $display("FAIL rst_fc: got %0d want 0", frame_cnt);
        end
        total++;
        if (active !== 1'b1 || line_start !== 1'b1 || frame_start !== 1'b1) begin
            bad++;
            $display("FAIL rst_flags: got act=%b ls=%b fs=%b want 1 1 1",
                     active, line_start, frame_start);
        end
        total++;
        if (hsync !== 1'b1 || vsync !== 1'b1 || rgb !== 3'b000) begin
            bad++;
            $display("FAIL rst_out: got hs=%b vs=%b rgb=%0d want 1 1 0",
                     hsync, vsync, rgb);
        end
        rst = 1'b0;
        mx  = 0;
        my  = 0;
        mfc = 0;
        q.delete();
        q.push_back(rst_out);
        last = rst_out;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        total++;
        if (x !== 10'd1 || y !== 10'd0) begin
            bad++;
            $display("FAIL first_pix: got x=%0d y=%0d want 1 0", x, y);
        end
    endtask

    task automatic test_full_frames();
        int hlow = 0;
        int vlow = 0;
        int r7 = 0;
        int last_fall = -1;
        logic prev_hs = 1'b1;
        mode = 0;
        do_reset(1'b1);
        for (int c = 0; c < 2 * HT * VT; c++) begin
            step(1'b1);
            if (!hsync) hlow++;
            if (!vsync) vlow++;
            if (rgb == 3'd7) r7++;
            if (prev_hs && !hsync) begin
                if (last_fall >= 0) begin
                    total++;
                    if (c - last_fall !== HT) begin
                        bad++;
                        $display("FAIL h_period: got %0d want %0d", c - last_fall, HT);
                    end
                end
                last_fall = c;
            end
            prev_hs = hsync;
        end
        total++;
        if (hlow !== 2 * VT * HS) begin
            bad++;
            $display("FAIL hsync_low: got %0d want %0d", hlow, 2 * VT * HS);
        end
        total++;
        if (vlow !== 2 * VS * HT) begin
            bad++;
            $display("FAIL vsync_low: got %0d want %0d", vlow, 2 * VS * HT);
        end
        total++;
        if (r7 !== 2 * HA * VA) begin
            bad++;
            $display("FAIL rgb_active: got %0d want %0d", r7, 2 * HA * VA);
        end
        total++;
        if (frame_cnt !== 8'd2) begin
            bad++;
            $display("FAIL fc_two: got %0d want 2", frame_cnt);
        end
    endtask

    task automatic test_alignment();
        logic [2:0] er;
        int p;
        mode = 1;
        do_reset(1'b1);
        for (int k = 1; k <= HA + 3; k++) begin
            step(1'b1);
            p  = k - 2;
            er = (p >= 0 && p < HA) ? p[2:0] : 3'b000;
            total++;
            if (rgb !== er) begin
                bad++;
                $display("FAIL align: step %0d got rgb=%0d want %0d", k, rgb, er);
            end
        end
        for (int c = 0; c < HT * VT; c++)
            step(1'b1);
    endtask

    task automatic test_slow();
        int hlow = 0;
        int r7 = 0;
        mode = 0;
        do_reset(1'b1);
        for (int c = 0; c < HT * VT; c++) begin
            for (int s = 0; s < 4; s++) begin
                step(s == 0);
                if (!hsync) hlow++;
                if (rgb == 3'd7) r7++;
            end
        end
        total++;
        if (hlow !== 4 * HS * VT) begin
            bad++;
            $display("FAIL slow_hlow: got %0d want %0d", hlow, 4 * HS * VT);
        end
        total++;
        if (r7 !== 4 * HA * VA) begin
            bad++;
            $display("FAIL slow_rgb: got %0d want %0d", r7, 4 * HA * VA);
        end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        mode = 0;
        do_reset(1'b1);
        step(1'b1);
        while (!(mx == HA + HF + 2 && my == VA + VF) && n < 2 * HT * VT) begin
            step(1'b1);
            n++;
        end
        total++;
        if (n >= 2 * HT * VT) begin
            bad++;
            $display("FAIL mid_reach: got steps=%0d want < %0d", n, 2 * HT * VT);
        end
        total++;
        if (hsync !== 1'b0 || vsync !== 1'b0) begin
            bad++;
            $display("FAIL pre_rst_sync: got hs=%b vs=%b want 0 0", hsync, vsync);
        end
        do_reset(1'b1);
        step(1'b1);
    endtask

    task automatic test_wrap();
        int n = 0;
        mode = 0;
        do_reset(1'b1);
        while (!(mx == HT - 1 && my == VT - 1) && n < HT * VT + 2) begin
            step(1'b1);
            n++;
        end
        step(1'b1);
        total++;
        if (frame_cnt !== 8'd1 || x !== 10'd0 || y !== 10'd0 || frame_start !== 1'b1) begin
            bad++;
            $display("FAIL wrap_first: got fc=%0d x=%0d y=%0d fs=%b want 1 0 0 1",
                     frame_cnt, x, y, frame_start);
        end
        n = 0;
        while (!(mfc == 255 && mx == HT - 1 && my == VT - 1) && n < 256 * HT * VT) begin
            step(1'b1);
            n++;
        end
        total++;
        if (frame_cnt !== 8'd255) begin
            bad++;
            $display("FAIL fc_255: got %0d want 255", frame_cnt);
        end
        step(1'b1);
        total++;
        if (frame_cnt !== 8'd0 || x !== 10'd0 || y !== 10'd0 || frame_start !== 1'b1) begin
            bad++;
            $display("FAIL wrap_256: got fc=%0d x=%0d y=%0d fs=%b want 0 0 0 1",
                     frame_cnt, x, y, frame_start);
        end
    endtask

    initial begin
        rst_out.hs  = 1'b1;
        rst_out.vs  = 1'b1;
        rst_out.rgb = 3'b000;
        last = rst_out;
        @(posedge clk);
        #1;
        test_reset();
        test_full_frames();
        test_alignment();
        test_slow();
        test_mid_reset();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters (one per line: name, default, meaning):
  H_ACTIVE, 640, visible pixels per line
  H_FP, 24, horizontal front porch (pixels)
  H_SYNC, 40, hsync pulse width (pixels)
  H_BP, 128, horizontal back porch (pixels); H total 832
  V_ACTIVE, 480, visible lines per frame
  V_FP, 9, vertical front porch (lines)
  V_SYNC, 3, vsync pulse width (lines)
  V_BP, 28, vertical back porch (lines); V total 520
REQ-002 SHALL have ports (name, direction, width, meaning):
  wb_clk_i  in  1  single clock; all logic on rising edge
  wb_rst_i  in  1  reset, synchronous, active-high
  pix_en  in  1  pixel strobe; one pixel step per cycle where high
  rgb_in  in  3  pixel colour from renderer for the (x,y) issued one pix_en step earlier
  x  out  10  current horizontal count (stage 0)
  y  out  10  current vertical count (stage 0)
  active  out  1  high when x<H_ACTIVE and y<V_ACTIVE (stage 0)
  line_start  out  1  high while x==0 (stage 0)
  frame_start  out  1  high while x==0 and y==0 (stage 0)
  frame_cnt  out  8  completed-frame counter
  hsync  out  1  horizontal sync, active-low, registered
  vsync  out  1  vertical sync, active-low, registered
  rgb  out  3  blanked colour, registered

Function
REQ-003 x SHALL count 0..H_total-1 on each pix_en, wrapping to 0; y SHALL increment on each x wrap, wrapping 0 after V_total-1.
REQ-004 Horizontal regions (defaults): active 0..639, front porch 640..663, sync 664..703, back porch 704..831.
REQ-005 Vertical regions (defaults): active 0..479, front porch 480..488, sync 489..491, back porch 492..519.
REQ-006 Stage-0 sync SHALL be low exactly in the sync region; porches and active SHALL keep sync high.
REQ-007 frame_cnt SHALL increment, modulo 256, on the pix_en step where x wraps and y wraps together.
REQ-008 Pipeline: stage 1 SHALL hold delayed hsync, vsync and active from stage 0; stage 2 (output registers) SHALL load hsync, vsync, and rgb = stage-1 active ? rgb_in : 3'b000.
REQ-009 hsync, vsync and rgb SHALL lag x/y/active by exactly 2 pix_en steps.
REQ-010 rgb SHALL be 0 whenever the output-stage hsync or vsync is low, or whenever the pixel is outside the active region, independent of rgb_in.
REQ-011 With pix_en low, all counters, pipeline stages and outputs SHALL hold their values.
REQ-012 rgb_in SHALL be sampled only on pix_en cycles.
REQ-013 Counter widths SHALL be 10 bits. Parameter sums above 1023 are unsupported.

Reset
REQ-014 When wb_rst_i is high at a clock edge, regardless of pix_en, the block SHALL set x=0, y=0, and frame_cnt=0.
REQ-015 The same reset SHALL set both pipeline stages to inactive: hsync=1, vsync=1, active=0, rgb=0.
REQ-016 A reset asserted mid-line or mid-frame SHALL take effect at the next edge. The first pix_en after release SHALL be pixel (0,0).
REQ-017 During reset, stage-0 outputs SHALL read x=0, y=0, active=1, line_start=1 and frame_start=1.

Verification
REQ-018 Reset, then pix_en tied high for 2 full frames (865280 cycles) -> per frame:
  - hsync low exactly 40 cycles in every line, with 832-cycle period;
  - vsync low exactly 3 lines (2496 cycles), with 432640-cycle period;
  - frame_cnt reads 2 at the end.
REQ-019 rgb_in held at 3'b111 -> rgb=7 for exactly 640 cycles per line on lines 0..479 (shifted 2 cycles) and 0 elsewhere, including all porch and sync cycles.
REQ-020 Alignment check:
  - drive rgb_in = x[2:0] delayed one step;
  - rgb SHALL equal x[2:0] of the pixel issued 2 steps earlier;
  - first visible rgb SHALL appear 2 cycles after frame_start.
REQ-021 pix_en high every 4th cycle -> all timings above scale exactly by 4; outputs stable across the 3 idle cycles.
REQ-022 Assert wb_rst_i for 1 cycle at x=700, y=490 (inside both syncs) -> next cycle hsync=1, vsync=1, rgb=0, x=0, y=0, frame_cnt=0.
REQ-023 Boundaries:
  - at x=831, y=519 with pix_en -> x=0, y=0, frame_start=1, frame_cnt increments;
  - with frame_cnt=255, the same step -> frame_cnt=0.
